time_base_gen: RTL and testbench

TIME_BASE_GEN -- requirements
Module: time_base_gen

---
 rtl/time_base_gen.sv | 109 ++++++++++
 tb/tb_time_base_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_base_gen.sv
// time_base_gen: one-second / half-second tick generator with a fast-set mode.
// The prescaler restarts its phase on every mode change, on sync, and while stopped.
module time_base_gen #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned FAST_FACTOR = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic fast,
  input  logic sync,
  output logic tc_time_base,
  output logic tc_half,
  output logic blink,
  output logic running
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [CW-1:0] RUN_TERM  = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF_TERM = CW'(CLK_HZ / 2 - 1);
  localparam logic [CW-1:0] FAST_TERM = CW'(CLK_HZ / FAST_FACTOR - 1);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    FAST = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            tc_nxt;
  logic            half_nxt;
  logic            blink_nxt;

  // Mode selection: run has priority, then fast.
  always_comb begin
    state_nxt = STOP;
    if (run) begin
      state_nxt = fast ? FAST : RUN;
    end
  end

  // Prescaler and tick generation for the current mode.
  // A mode change wins over sync and over a coinciding terminal count, so
  // that tick is dropped and the new mode starts from a clean phase.
  always_comb begin
    cnt_nxt   = '0;
    tc_nxt    = 1'b0;
    half_nxt  = 1'b0;
    blink_nxt = blink;
    if (state_nxt != state) begin
      blink_nxt = (state_nxt == FAST);
    end else begin
      case (state)
        RUN: begin
          if (sync) begin
            blink_nxt = 1'b0;
          end else begin
            if (cnt == RUN_TERM) begin
              tc_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
            if ((cnt == HALF_TERM) || (cnt == RUN_TERM)) begin
              half_nxt  = 1'b1;
              blink_nxt = ~blink;
            end
          end
        end
        FAST: begin
          blink_nxt = 1'b1;
          if (!sync) begin
            if (cnt == FAST_TERM) begin
              tc_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        default: begin
          blink_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, prescaler and registered outputs; reset clears all asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= STOP;
      cnt          <= '0;
      tc_time_base <= 1'b0;
      tc_half      <= 1'b0;
      blink        <= 1'b0;
      running      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      tc_time_base <= tc_nxt;
      tc_half      <= half_nxt;
      blink        <= blink_nxt;
      running      <= (state_nxt != STOP);
    end
  end

endmodule

// File: tb/tb_time_base_gen.sv
// tb_time_base_gen: scenario tasks plus a randomized run, checked against an
// elapsed-time reference model of the tick generator.
module tb_time_base_gen;

  localparam int unsigned CLK_HZ      = 8;
  localparam int unsigned FAST_FACTOR = 4;

  logic clk;
  logic reset;
  logic run;
  logic fast;
  logic sync;
  logic tc_time_base;
  logic tc_half;
  logic blink;
  logic running;

  int checks;
  int errors;

  time_base_gen #(
    .CLK_HZ     (CLK_HZ),
    .FAST_FACTOR(FAST_FACTOR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .fast        (fast),
    .sync        (sync),
    .tc_time_base(tc_time_base),
    .tc_half     (tc_half),
    .blink       (blink),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0=stopped, 1=normal, 2=fast; t = cycles since phase restart.
  int   m_mode;
  int   m_t;
  int   m_halves;
  logic m_tc;
  logic m_half;
  logic m_blink;
  logic m_running;

  function automatic logic [3:0] model_out();
    return {m_tc, m_half, m_blink, m_running};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_halves = 0;
    m_tc = 0; m_half = 0; m_blink = 0; m_running = 0;
  endtask

  task automatic model_step(input logic r, input logic f, input logic s);
    int nm;
    int period;
    nm = !r ? 0 : (f ? 2 : 1);
    if (nm != m_mode || nm == 0 || s) begin
      m_t = 0; m_halves = 0;
      m_tc = 0; m_half = 0;
      m_blink = (nm == 2);
    end else begin
      m_t++;
      period = (nm == 1) ? CLK_HZ : CLK_HZ / FAST_FACTOR;
      m_tc = (m_t % period == 0);
      if (nm == 1) begin
        m_half = (m_t % (CLK_HZ / 2) == 0);
        if (m_half) m_halves++;
        m_blink = m_halves[0];
      end else begin
        m_half = 0;
        m_blink = 1;
      end
    end
    m_mode = nm;
    m_running = (nm != 0);
  endtask

  // Advance one clock edge, step the model, and leave time for outputs to settle.
  task automatic cycle();
    @(posedge clk);
    model_step(run, fast, sync);
    #1;
  endtask

  task automatic test_reset();
    run = 0; fast = 0; sync = 0; reset = 0;
    model_reset();
    #23;
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({tc_time_base, tc_half, blink, running} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle: got %b want 0000", {tc_time_base, tc_half, blink, running});
      end
    end
  endtask

  task automatic test_run();
    int first;
    int ticks;
    int halves;
    first = -1; ticks = 0; halves = 0;
    run = 1; fast = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks++;
      if ({tc_time_base, tc_half, blink, running} !== model_out()) begin
        errors++;
        $display("FAIL run_cycle%0d: got %b want %b", i, {tc_time_base, tc_half, blink, running}, model_out());
      end
      if (tc_time_base && first < 0) first = i;
      ticks  += int'(tc_time_base);
      halves += int'(tc_half);
    end
    checks++;
    if (first !== 8) begin
      errors++;
      $display("FAIL run_first_tick: got %0d want 8", first);
    end
    checks++;
    if (ticks !== 4 || halves !== 9) begin
      errors++;
      $display("FAIL run_tick_counts: got ticks=%0d halves=%0d want 4 9", ticks, halves);
    end
  endtask

  task automatic test_fast();
    int ticks;
    int first;
    ticks = 0; first = -1;
    fast = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if ({tc_time_base, tc_half, blink, running} !== model_out()) begin
        errors++;
        $display("FAIL fast_cycle%0d: got %b want %b", i, {tc_time_base, tc_half, blink, running}, model_out());
      end
      ticks += int'(tc_time_base);
    end
    checks++;
    if (ticks !== 5) begin
      errors++;
      $display("FAIL fast_tick_count: got %0d want 5", ticks);
    end
    fast = 0;
    for (int i = 0; i < 12 && first < 0; i++) begin
      cycle();
      if (tc_time_base) first = i;
    end
    checks++;
    if (first !== 8) begin
      errors++;
      $display("FAIL fast_exit_first_tick: got %0d want 8", first);
    end
  endtask

  task automatic test_sync();
    int n;
    int gap;
    n = 0; gap = -1;
    while ((m_t % CLK_HZ) != 7 && n < 20) begin
      cycle();
      n++;
    end
    sync = 1;
    cycle();
    sync = 0;
    checks++;
    if ({tc_time_base, tc_half, blink} !== 3'b000) begin
      errors++;
      $display("FAIL sync_drop: got %b want 000", {tc_time_base, tc_half, blink});
    end
    for (int i = 1; i <= 12 && gap < 0; i++) begin
      cycle();
      if (tc_time_base) gap = i;
    end
    checks++;
    if (gap !== 8) begin
      errors++;
      $display("FAIL sync_next_tick: got %0d want 8", gap);
    end
  endtask

  task automatic test_run_drop();
    int n;
    int first;
    n = 0; first = -1;
    while ((m_t % CLK_HZ) != 5 && n < 20) begin
      cycle();
      n++;
    end
    run = 0;
    cycle();
    checks++;
    if ({tc_time_base, tc_half, blink, running} !== 4'b0000) begin
      errors++;
      $display("FAIL run_drop: got %b want 0000", {tc_time_base, tc_half, blink, running});
    end
    run = 1;
    for (int i = 0; i < 12 && first < 0; i++) begin
      cycle();
      if (tc_time_base) first = i;
    end
    checks++;
    if (first !== 8) begin
      errors++;
      $display("FAIL rerun_first_tick: got %0d want 8", first);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle();
    #3;
    reset = 0;
    model_reset();
    #1;
    checks++;
    if ({tc_time_base, tc_half, blink, running} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b want 0000", {tc_time_base, tc_half, blink, running});
    end
    #10;
    run = 0;
    reset = 1;
    sync = 1;
    cycle();
    sync = 0;
    cycle();
    checks++;
    if ({tc_time_base, tc_half, blink, running} !== 4'b0000) begin
      errors++;
      $display("FAIL sync_in_stop: got %b want 0000", {tc_time_base, tc_half, blink, running});
    end
  endtask

  task automatic test_random();
    logic prev_tc;
    logic prev_half;
    prev_tc = 0; prev_half = 0;
    for (int i = 0; i < 400; i++) begin
      run  = ($urandom_range(0, 15) != 0);
      fast = ($urandom_range(0, 7) == 0) ? ~fast : fast;
      sync = ($urandom_range(0, 19) == 0);
      cycle();
      checks++;
      if ({tc_time_base, tc_half, blink, running} !== model_out()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b want %b", i, {tc_time_base, tc_half, blink, running}, model_out());
      end
      checks++;
      if ((prev_tc && tc_time_base) || (prev_half && tc_half)) begin
        errors++;
        $display("FAIL random_pulse_width%0d: tc %b%b half %b%b want no back-to-back", i, prev_tc, tc_time_base, prev_half, tc_half);
      end
      prev_tc = tc_time_base;
      prev_half = tc_half;
    end
    sync = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_run();
    test_fast();
    test_sync();
    test_run_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
